wb_trace_buffer: RTL



---
 rtl/wb_trace_buffer.sv | 103 ++++++++++
 1 files changed

// File: rtl/wb_trace_buffer.sv
// Retirement trace buffer: captures committed register writebacks, tags each
// with a 16-bit sequence number and queues them in a circular FIFO drained by
// a valid/ready sink. Overflow drops the event, counts it and sets a sticky
// flag; the pipeline is never stalled.
module wb_trace_buffer #(
  parameter int DEPTH     = 8,
  parameter int FILTER_X0 = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_e,
  input  logic [4:0]               wb_a,
  input  logic [31:0]              wb_d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_addr,
  output logic [31:0]              out_data,
  output logic [15:0]              out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [4:0]    mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [15:0]   mem_seq  [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [15:0]   seq;

  logic qualify;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Event qualification and push/pop/drop decisions for this cycle
  always_comb begin
    qualify = wb_e && !((FILTER_X0 != 0) && (wb_a == 5'd0));
    full    = (level == LW'(DEPTH));
    pop     = out_valid && out_ready;
    push    = qualify && (!full || pop);
    drop    = qualify && full && !pop;
  end

  // Head entry is always presented straight from the read pointer
  always_comb begin
    out_valid = (level != '0);
    out_addr  = mem_addr[rd_ptr];
    out_data  = mem_data[rd_ptr];
    out_seq   = mem_seq[rd_ptr];
  end

  // Storage write at the tail; cleared on reset so the head is never X
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
        mem_seq[i]  <= '0;
      end
    end else if (push) begin
      mem_addr[wr_ptr] <= wb_a;
      mem_data[wr_ptr] <= wb_d;
      mem_seq[wr_ptr]  <= seq;
    end
  end

  // Pointers, occupancy, sequence counter and overflow bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      // Every qualifying event consumes a number, queued or dropped, so the
      // sink can spot gaps in out_seq.
      if (qualify)
        seq <= seq + 16'd1;
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule
